// File: rtl/mem_responder_if.sv
// Request/response bus between the data-cache side and the memory responder.
interface mem_responder_if #(
  parameter int PA_WIDTH   = 32,
  parameter int REG_WIDTH  = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ID_WIDTH   = 4
);
  logic                  i_mem_enable;
  logic                  i_mem_write;
  logic [PA_WIDTH-1:0]   i_mem_addr;
  logic [REG_WIDTH-1:0]  i_mem_data;
  logic                  i_mem_ack;
  logic                  o_mem_ready;
  logic [ID_WIDTH-1:0]   o_mem_id_request;
  logic                  o_mem_enable;
  logic [LINE_WIDTH-1:0] o_mem_data;
  logic [ID_WIDTH-1:0]   o_mem_id_response;

  modport master (
    output i_mem_enable, i_mem_write, i_mem_addr, i_mem_data, i_mem_ack,
    input  o_mem_ready, o_mem_id_request, o_mem_enable, o_mem_data, o_mem_id_response
  );

  modport slave (
    input  i_mem_enable, i_mem_write, i_mem_addr, i_mem_data, i_mem_ack,
    output o_mem_ready, o_mem_id_request, o_mem_enable, o_mem_data, o_mem_id_response
  );
endinterface

// File: rtl/mem_responder.sv
// Main-memory model: word writes, in-order line reads returned after a fixed
// latency through a small snapshot queue with valid/ack response handshake.
module mem_responder #(
  parameter int PA_WIDTH    = 32,
  parameter int REG_WIDTH   = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int ID_WIDTH    = 4,
  parameter int MEM_LINES   = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);
  localparam int OFF     = $clog2(LINE_WIDTH / 8);
  localparam int WSEL_LO = $clog2(REG_WIDTH / 8);
  localparam int WBITS   = OFF - WSEL_LO;
  localparam int LIDX    = $clog2(MEM_LINES);
  localparam int PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW      = $clog2(QUEUE_DEPTH + 1);
  localparam int AW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // Stored age counts edges until the registered valid may rise, so an entry
  // with age 0 after an edge is presented in the cycle that follows it.
  localparam logic [AW-1:0] AGE_INIT = AW'(LATENCY - 1);

  typedef logic [LINE_WIDTH-1:0] line_t;

  line_t                mem_q   [MEM_LINES];
  line_t                qdata_q [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]  qid_q   [QUEUE_DEPTH];
  logic [AW-1:0]        qage_q  [QUEUE_DEPTH];
  logic [AW-1:0]        qage_d  [QUEUE_DEPTH];

  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic                 en_q, en_d;
  line_t                data_q, data_d;
  logic [ID_WIDTH-1:0]  rid_q, rid_d;

  logic [LIDX-1:0]      line_idx;
  logic [WBITS-1:0]     word_sel;
  logic                 ready, accept, push, wr, pop, head_new;
  logic                 unused_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign line_idx    = bus.i_mem_addr[OFF +: LIDX];
  assign word_sel    = bus.i_mem_addr[WSEL_LO +: WBITS];
  assign unused_addr = ^{bus.i_mem_addr[PA_WIDTH-1:OFF+LIDX], bus.i_mem_addr[WSEL_LO-1:0]};

  assign ready  = cnt_q < CW'(QUEUE_DEPTH);
  assign accept = rst && bus.i_mem_enable && ready;
  assign push   = accept && !bus.i_mem_write;
  assign wr     = accept && bus.i_mem_write;
  assign pop    = en_q && bus.i_mem_ack;

  assign bus.o_mem_ready       = ready;
  assign bus.o_mem_id_request  = id_q;
  assign bus.o_mem_enable      = en_q;
  assign bus.o_mem_data        = data_q;
  assign bus.o_mem_id_response = rid_q;

  // Next queue state, ages and the response register contents.
  always_comb begin
    rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    id_d  = push ? id_q + 1'b1 : id_q;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      qage_d[i] = (qage_q[i] == '0) ? '0 : qage_q[i] - 1'b1;
      if (push && (PW'(i) == wr_q)) qage_d[i] = AGE_INIT;
    end
    // Entry being pushed is also the new head when the queue drains to it.
    head_new = push && (cnt_q == CW'(pop));
    en_d     = (cnt_d != '0) && (qage_d[rd_d] == '0);
    data_d   = data_q;
    rid_d    = rid_q;
    if (en_d) begin
      data_d = head_new ? mem_q[line_idx] : qdata_q[rd_d];
      rid_d  = head_new ? id_q : qid_q[rd_d];
    end
  end

  // Queue control, ID counter and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      en_q   <= 1'b0;
      data_q <= '0;
      rid_q  <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) qage_q[i] <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      id_q   <= id_d;
      en_q   <= en_d;
      data_q <= data_d;
      rid_q  <= rid_d;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) qage_q[i] <= qage_d[i];
    end
  end

  // Storage array and queued line snapshots; neither is cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      qdata_q[wr_q] <= mem_q[line_idx];
      qid_q[wr_q]   <= id_q;
    end
    if (wr) mem_q[line_idx][word_sel*REG_WIDTH +: REG_WIDTH] <= bus.i_mem_data;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;
  localparam int PA_WIDTH    = 32;
  localparam int REG_WIDTH   = 32;
  localparam int LINE_WIDTH  = 128;
  localparam int ID_WIDTH    = 4;
  localparam int MEM_LINES   = 256;
  localparam int LATENCY     = 4;
  localparam int QUEUE_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.PA_WIDTH(PA_WIDTH), .REG_WIDTH(REG_WIDTH),
                     .LINE_WIDTH(LINE_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

  mem_responder #(
    .PA_WIDTH(PA_WIDTH), .REG_WIDTH(REG_WIDTH), .LINE_WIDTH(LINE_WIDTH),
    .ID_WIDTH(ID_WIDTH), .MEM_LINES(MEM_LINES), .LATENCY(LATENCY),
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.i_mem_enable = 1'b1;
    bus.i_mem_write  = w;
    bus.i_mem_addr   = a;
    bus.i_mem_data   = d;
    tick();
    bus.i_mem_enable = 1'b0;
    bus.i_mem_write  = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (!bus.o_mem_enable && n < 20) begin
      tick();
      n++;
    end
    if (!bus.o_mem_enable) chk({tag, "_timeout"}, 128'(bus.o_mem_enable), 128'd1);
  endtask

  task automatic ack_one();
    bus.i_mem_ack = 1'b1;
    tick();
    bus.i_mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.i_mem_enable = 1'b0;
    bus.i_mem_write  = 1'b0;
    bus.i_mem_addr   = '0;
    bus.i_mem_data   = '0;
    bus.i_mem_ack    = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk("rst_en",    128'(bus.o_mem_enable), 128'd0);
    chk("rst_data",  bus.o_mem_data, 128'd0);
    chk("rst_rid",   128'(bus.o_mem_id_response), 128'd0);
    chk("rst_idreq", 128'(bus.o_mem_id_request), 128'd0);
    chk("rst_ready", 128'(bus.o_mem_ready), 128'd1);
    rst = 1'b1;
    tick();

    // 1: write then read, exact latency
    issue(1'b1, 32'h104, 32'hDEADBEEF);
    chk("t1_idreq", 128'(bus.o_mem_id_request), 128'd0);
    issue(1'b0, 32'h100, 32'h0);
    tick();
    tick();
    chk("t1_en_early", 128'(bus.o_mem_enable), 128'd0);
    tick();
    chk("t1_en",   128'(bus.o_mem_enable), 128'd1);
    chk("t1_rid",  128'(bus.o_mem_id_response), 128'd0);
    chk("t1_data", 128'(bus.o_mem_data[63:32]), 128'hDEADBEEF);
    ack_one();
    chk("t1_en_after_ack", 128'(bus.o_mem_enable), 128'd0);

    // 2: fill the queue, hold, then drain back-to-back
    do_reset();
    bus.i_mem_enable = 1'b1;
    bus.i_mem_write  = 1'b0;
    bus.i_mem_addr   = 32'h100;
    for (int i = 0; i < 4; i++) begin
      chk("t2_idreq", 128'(bus.o_mem_id_request), 128'(i));
      tick();
    end
    chk("t2_ready_full", 128'(bus.o_mem_ready), 128'd0);
    chk("t2_en",         128'(bus.o_mem_enable), 128'd1);
    chk("t2_rid0",       128'(bus.o_mem_id_response), 128'd0);
    tick();
    bus.i_mem_enable = 1'b0;
    chk("t2_no_accept_full", 128'(bus.o_mem_id_request), 128'd4);
    chk("t2_hold_rid",       128'(bus.o_mem_id_response), 128'd0);
    chk("t2_hold_data",      128'(bus.o_mem_data[63:32]), 128'hDEADBEEF);
    tick();
    chk("t2_hold_rid2", 128'(bus.o_mem_id_response), 128'd0);
    bus.i_mem_ack = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_drain_en",  128'(bus.o_mem_enable), 128'd1);
      chk("t2_drain_rid", 128'(bus.o_mem_id_response), 128'(i));
      if (i == 1) chk("t2_ready_back", 128'(bus.o_mem_ready), 128'd1);
    end
    tick();
    bus.i_mem_ack = 1'b0;
    chk("t2_drained", 128'(bus.o_mem_enable), 128'd0);

    // 3: read snapshot unaffected by a following write
    issue(1'b1, 32'h200, 32'h22222222);
    issue(1'b0, 32'h200, 32'h0);
    issue(1'b1, 32'h200, 32'h11111111);
    wait_resp("t3a");
    chk("t3_old_word", 128'(bus.o_mem_data[31:0]), 128'h22222222);
    ack_one();
    issue(1'b0, 32'h200, 32'h0);
    wait_resp("t3b");
    chk("t3_new_word", 128'(bus.o_mem_data[31:0]), 128'h11111111);
    ack_one();

    // 4: ID wrap after 16 reads
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("t4_wrap_idreq", 128'(bus.o_mem_id_request), 128'd0);
      issue(1'b0, 32'h0, 32'h0);
      wait_resp("t4");
      chk("t4_rid", 128'(bus.o_mem_id_response), 128'(i % 16));
      ack_one();
    end

    // 5: reset with reads in flight; write during reset is dropped
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h100, 32'h0);
    wait_resp("t5");
    chk("t5_en_pre", 128'(bus.o_mem_enable), 128'd1);
    #1;
    rst = 1'b0;
    bus.i_mem_enable = 1'b1;
    bus.i_mem_write  = 1'b1;
    bus.i_mem_addr   = 32'h104;
    bus.i_mem_data   = 32'hBAD0BAD0;
    #1;
    chk("t5_en_async",  128'(bus.o_mem_enable), 128'd0);
    chk("t5_ready",     128'(bus.o_mem_ready), 128'd1);
    chk("t5_idreq",     128'(bus.o_mem_id_request), 128'd0);
    chk("t5_rid",       128'(bus.o_mem_id_response), 128'd0);
    chk("t5_data",      bus.o_mem_data, 128'd0);
    tick();
    tick();
    bus.i_mem_enable = 1'b0;
    bus.i_mem_write  = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.o_mem_enable;
    end
    chk("t5_no_resp", 128'(seen), 128'd0);
    chk("t5_idreq_after", 128'(bus.o_mem_id_request), 128'd0);
    issue(1'b0, 32'h100, 32'h0);
    wait_resp("t5b");
    chk("t5_rid_after",   128'(bus.o_mem_id_response), 128'd0);
    chk("t5_write_drop",  128'(bus.o_mem_data[63:32]), 128'hDEADBEEF);
    ack_one();

    // 6: high address bits alias; stray ack is ignored
    issue(1'b1, 32'h1000, 32'hCAFEF00D);
    issue(1'b0, 32'h0, 32'h0);
    wait_resp("t6a");
    chk("t6_alias", 128'(bus.o_mem_data[31:0]), 128'hCAFEF00D);
    chk("t6_rid",   128'(bus.o_mem_id_response), 128'd1);
    ack_one();
    ack_one();
    chk("t6_stray_en",    128'(bus.o_mem_enable), 128'd0);
    chk("t6_stray_ready", 128'(bus.o_mem_ready), 128'd1);
    chk("t6_stray_idreq", 128'(bus.o_mem_id_request), 128'd2);
    issue(1'b0, 32'h0, 32'h0);
    wait_resp("t6b");
    chk("t6_rid2",  128'(bus.o_mem_id_response), 128'd2);
    chk("t6_data2", 128'(bus.o_mem_data[31:0]), 128'hCAFEF00D);
    ack_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory model and controller at the far end of the data-memory request/response interface.
- Accepts single-word writes and line-read requests from the data cache side.
- Assigns a transaction ID to every read and returns whole lines after a fixed latency, in order, under a valid/ack handshake.
- Used as the backing store in core-level simulation; synthesisable for FPGA bring-up.

Parameters:
PA_WIDTH, 32, physical byte-address width
REG_WIDTH, 32, write-data word width (multiple of 8)
LINE_WIDTH, 128, response line width (multiple of REG_WIDTH)
ID_WIDTH, 4, transaction ID width
MEM_LINES, 256, number of stored lines (power of 2)
LATENCY, 4, cycles from read accept to earliest response (>=1)
QUEUE_DEPTH, 4, maximum outstanding reads (power of 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_mem_enable  in  1  request valid
i_mem_write  in  1  1 = word write, 0 = line read
i_mem_addr  in  PA_WIDTH  byte address
i_mem_data  in  REG_WIDTH  write word
i_mem_ack  in  1  requester consumes the presented response
o_mem_ready  out  1  request may be accepted this cycle
o_mem_id_request  out  ID_WIDTH  ID given to a read accepted this cycle
o_mem_enable  out  1  response valid
o_mem_data  out  LINE_WIDTH  response line
o_mem_id_response  out  ID_WIDTH  ID of the presented response

Behaviour:
- Address decode:
  - OFF = log2(LINE_WIDTH/8) low bits select the byte within the line.
  - Word select = addr[OFF-1 : log2(REG_WIDTH/8)].
  - Line index = next log2(MEM_LINES) bits.
  - Higher bits are ignored, so addresses alias.
  - Sub-word offset bits are ignored.
- Accept: request accepted on a rising edge where i_mem_enable && o_mem_ready.
- o_mem_ready = (outstanding count < QUEUE_DEPTH). This is combinational from registered state, with no same-cycle pop credit: when full, nothing is accepted even in a cycle where a response is popped.
- Write:
  - Selected word of the line updated at the accept edge.
  - No response generated, no ID consumed.
- Read accept:
  - Pushes the entry {id, line snapshot, age = LATENCY} into the in-order queue.
  - Snapshot is the array content before this edge.
  - ID counter increments modulo 2^ID_WIDTH.
  - o_mem_id_request always shows the current counter value; it is meaningful in the cycle a read is accepted.
- Age handling: each queued entry's age decrements every cycle, saturating at 0.
- Response presentation:
  - o_mem_enable is registered and goes high when the head entry's age is 0.
  - A read accepted at edge T therefore presents at the earliest after edge T+LATENCY-1, i.e. it is visible LATENCY cycles after accept.
  - o_mem_data and o_mem_id_response stay stable while o_mem_enable=1 and i_mem_ack=0.
- Pop:
  - Occurs on an edge with o_mem_enable && i_mem_ack.
  - If the next entry's age is already 0, it is presented the following cycle (back-to-back, no bubble). Otherwise o_mem_enable drops.
- i_mem_ack while o_mem_enable=0 is ignored.
- Ordering: responses always in accept order. A write after a read to the same line never alters that read's data; a write before a read is always visible to it.
- Push and pop on the same edge: count unchanged, both take effect.
- Reset (asserted, async):
  - o_mem_enable=0, o_mem_data=0, o_mem_id_response=0.
  - ID counter=0, so o_mem_id_request=0.
  - Queue emptied, so o_mem_ready=1.
- Reset mid-operation: in-flight reads are discarded with no response, and the ID counter restarts at 0.
- Memory array contents are not affected by reset and are undefined until written.
- Requests with i_mem_enable=1 while rst is asserted are dropped.

Test Plan:
1. Write 0xDEADBEEF to 0x104, then read 0x100 at edge T -> o_mem_enable=1 LATENCY(4) cycles after T, o_mem_id_response=0, o_mem_data[63:32]=0xDEADBEEF.
2. Four back-to-back reads with ack low -> o_mem_id_request 0,1,2,3; o_mem_ready=0 after the 4th accept; first response held stable. Then ack held high -> IDs 0,1,2,3 on consecutive cycles, and o_mem_ready returns to 1 after the first pop.
3. Read 0x200 then write 0x11111111 to 0x200 on the next cycle -> response carries the old word. A second read returns 0x11111111.
4. Seventeen reads with ID_WIDTH=4, each acked -> the 17th read gets ID 0 (wrap).
5. Assert rst with 3 reads outstanding -> o_mem_enable=0 immediately, no response after release, and the next read gets ID 0.
6. Write 0xCAFEF00D to 0x1000 (aliases line 0 when MEM_LINES=256), read 0x0 -> word 0 = 0xCAFEF00D. A stray i_mem_ack with no valid response causes no state change.
